// File: rtl/life_matrix_driver.sv
// life_matrix_driver: double-buffers 8x8 Life generations and scans them row by row
// onto a row-multiplexed LED matrix, swapping generations only at frame boundaries.
module life_matrix_driver #(
    parameter int DWELL = 4,
    parameter int BLANK = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] grid,
    input  logic        grid_valid,
    input  logic        enable,
    output logic [7:0]  row_sel,
    output logic [7:0]  col_data,
    output logic        frame_done,
    output logic        busy
);
    localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW = $clog2(MAXC + 1);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHOW, S_BLANK} state_t;
    state_t          r_state;
    logic [63:0]     r_pend_buf;
    logic [63:0]     r_disp_buf;
    logic            r_pend_flag;
    logic [2:0]      r_row;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_row_sel;
    logic [7:0]      r_col_data;
    logic            r_frame_done;
    logic            r_busy;
    logic [2:0]      w_row_nx;
    logic            w_cnt_zero;
    logic            w_row_end;
    logic [63:0]     w_load_src;
    assign w_row_nx   = r_row + 3'd1;
    assign w_cnt_zero = (r_cnt == '0);
    // With no blanking a row ends straight out of SHOW.
    assign w_row_end  = w_cnt_zero && (r_state == S_BLANK || (r_state == S_SHOW && BLANK == 0));
    assign w_load_src = r_pend_flag ? r_pend_buf : r_disp_buf;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pend_buf   <= '0;
            r_disp_buf   <= '0;
            r_pend_flag  <= 1'b0;
            r_row        <= '0;
            r_cnt        <= '0;
            r_row_sel    <= '0;
            r_col_data   <= '0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (enable) begin
                    r_state <= S_LOAD;
                    r_busy  <= 1'b1;
                end
            end else if (r_state == S_LOAD) begin
                r_disp_buf  <= w_load_src;
                r_pend_flag <= 1'b0;
                r_row       <= 3'd0;
                r_cnt       <= CW'(DWELL - 1);
                r_row_sel   <= 8'h01;
                r_col_data  <= w_load_src[7:0];
                r_state     <= S_SHOW;
            end else if (w_row_end && r_row != 3'd7) begin
                r_row      <= w_row_nx;
                r_cnt      <= CW'(DWELL - 1);
                r_row_sel  <= 8'h01 << w_row_nx;
                r_col_data <= r_disp_buf[{w_row_nx, 3'b000} +: 8];
                r_state    <= S_SHOW;
            end else if (w_row_end) begin
                r_frame_done <= 1'b1;
                r_row_sel    <= '0;
                r_col_data   <= '0;
                r_state      <= enable ? S_LOAD : S_IDLE;
                r_busy       <= enable;
            end else if (w_cnt_zero) begin
                r_row_sel  <= '0;
                r_col_data <= '0;
                r_cnt      <= CW'(BLANK - 1);
                r_state    <= S_BLANK;
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
            // Placed last so a strobe during LOAD re-arms the pending flag.
            if (grid_valid) begin
                r_pend_buf  <= grid;
                r_pend_flag <= 1'b1;
            end
        end
    end
    assign row_sel    = r_row_sel;
    assign col_data   = r_col_data;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;
endmodule

// File: tb/tb_life_matrix_driver.sv
// tb_life_matrix_driver: two driver instances (defaults and DWELL=1/BLANK=0) checked
// every cycle against a frame-position model, plus directed literal expectations.
module tb_life_matrix_driver;
    logic        clk = 0;
    logic        reset = 0;
    logic        grid_valid = 0;
    logic        enable = 0;
    logic [63:0] grid = '0;
    logic [7:0]  o_rs [2];
    logic [7:0]  o_cd [2];
    logic        o_fd [2];
    logic        o_busy [2];
    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int base = 0;
    int md [2] = '{4, 1};
    int mb [2] = '{1, 0};
    logic        m_act  [2] = '{default: 0};
    int          m_pos  [2] = '{default: 0};
    logic [63:0] m_pend [2] = '{default: 0};
    logic        m_pf   [2] = '{default: 0};
    logic [63:0] m_disp [2] = '{default: 0};
    logic        m_done [2] = '{default: 0};
    logic [7:0] rs_tab [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [7:0] col_tab [8] = '{8'h28, 8'h3C, 8'h34, 8'h00, 8'h24, 8'h64, 8'h12, 8'h04};
    localparam logic [63:0] G1 = 64'h0412_6424_0034_3C28;
    localparam logic [63:0] G2 = 64'h0102_0304_0506_0708;
    localparam logic [63:0] G3 = 64'h8040_2010_0804_0201;

    life_matrix_driver #(.DWELL(4), .BLANK(1)) u0 (
        .clk(clk), .reset(reset), .grid(grid), .grid_valid(grid_valid), .enable(enable),
        .row_sel(o_rs[0]), .col_data(o_cd[0]), .frame_done(o_fd[0]), .busy(o_busy[0]));
    life_matrix_driver #(.DWELL(1), .BLANK(0)) u1 (
        .clk(clk), .reset(reset), .grid(grid), .grid_valid(grid_valid), .enable(enable),
        .row_sel(o_rs[1]), .col_data(o_cd[1]), .frame_done(o_fd[1]), .busy(o_busy[1]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc - base - 1 < c) @(negedge clk);
    endtask

    // Model: a frame is LOAD followed by 8 rows of (DWELL show + BLANK dark) cycles.
    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_act[i] = 0; m_pos[i] = 0; m_pend[i] = '0; m_pf[i] = 0; m_disp[i] = '0; m_done[i] = 0;
            end else begin
                m_done[i] = 0;
                if (!m_act[i]) begin
                    if (enable) begin m_act[i] = 1; m_pos[i] = 0; end
                end else if (m_pos[i] == 0) begin
                    if (m_pf[i]) begin m_disp[i] = m_pend[i]; m_pf[i] = 0; end
                    m_pos[i] = 1;
                end else if (m_pos[i] == 8 * (md[i] + mb[i])) begin
                    m_done[i] = 1;
                    if (enable) m_pos[i] = 0;
                    else m_act[i] = 0;
                end else begin
                    m_pos[i]++;
                end
                if (grid_valid) begin m_pend[i] = grid; m_pf[i] = 1; end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [7:0] ers, ecd;
            int k, r, o;
            ers = '0; ecd = '0;
            if (m_act[i] && m_pos[i] >= 1) begin
                k = m_pos[i] - 1;
                r = k / (md[i] + mb[i]);
                o = k % (md[i] + mb[i]);
                if (o < md[i]) begin
                    ers = 8'h01 << r;
                    ecd = m_disp[i][8*r +: 8];
                end
            end
            chk($sformatf("row_sel[%0d]", i), o_rs[i], ers);
            chk($sformatf("col_data[%0d]", i), o_cd[i], ecd);
            chk($sformatf("frame_done[%0d]", i), o_fd[i], m_done[i]);
            chk($sformatf("busy[%0d]", i), o_busy[i], m_act[i]);
        end
    end

    initial begin
        #1 reset = 1;
        repeat (3) @(negedge clk);
        chk("reset_row_sel", o_rs[0], 8'h00);
        chk("reset_busy", o_busy[0], 0);
        chk("reset_frame_done", o_fd[0], 0);
        reset = 0;
        @(negedge clk);
        chk("idle_busy", o_busy[0], 0);
        grid = G1; grid_valid = 1; enable = 1; base = cyc;
        goto(0);
        grid_valid = 0;
        chk("load_busy", o_busy[0], 1);
        chk("load_row_sel", o_rs[0], 8'h00);
        for (int c = 1; c <= 41; c++) begin
            goto(c);
            if (c <= 40) begin
                chk("t1_row_sel", o_rs[0], ((c - 1) % 5 < 4) ? rs_tab[(c - 1) / 5] : 8'h00);
                chk("t1_col_data", o_cd[0], ((c - 1) % 5 < 4) ? col_tab[(c - 1) / 5] : 8'h00);
            end else begin
                chk("t1_frame_done_41", o_fd[0], 1);
            end
            if (c <= 8) begin
                chk("d1_row_sel", o_rs[1], rs_tab[c - 1]);
                chk("d1_col_data", o_cd[1], col_tab[c - 1]);
            end
            if (c == 9) chk("d1_frame_done_9", o_fd[1], 1);
        end
        goto(57);
        grid = '1; grid_valid = 1;
        goto(58);
        grid_valid = 0;
        chk("t2_row3_old", o_cd[0], 8'h00);
        chk("t2_row3_sel", o_rs[0], 8'h08);
        goto(83);
        chk("t2_next_frame_ff", o_cd[0], 8'hFF);
        goto(100);
        grid = G3; grid_valid = 1;
        goto(101);
        grid_valid = 0;
        goto(123);
        grid = G2; grid_valid = 1;
        goto(124);
        grid_valid = 0;
        chk("t3_old_pend", o_cd[0], 8'h01);
        goto(165);
        chk("t3_new_pend", o_cd[0], 8'h08);
        goto(175);
        enable = 0;
        goto(205);
        chk("t4_frame_done", o_fd[0], 1);
        chk("t4_busy_off", o_busy[0], 0);
        goto(208);
        chk("t4_idle_busy", o_busy[0], 0);
        chk("t4_idle_row_sel", o_rs[0], 8'h00);
        enable = 1;
        goto(209);
        chk("t4_reload", o_busy[0], 1);
        goto(236);
        grid = G1; grid_valid = 1;
        goto(237);
        grid_valid = 0;
        chk("t5_pre_row_sel", o_rs[0], 8'h20);
        chk("t5_pre_col", o_cd[0], 8'h03);
        #2 reset = 1;
        #1;
        chk("t5_async_row_sel", o_rs[0], 8'h00);
        chk("t5_async_col", o_cd[0], 8'h00);
        chk("t5_async_busy", o_busy[0], 0);
        chk("t5_async_done", o_fd[0], 0);
        chk("t5_async_busy1", o_busy[1], 0);
        @(negedge clk);
        reset = 0; base = cyc;
        goto(1);
        chk("t5_blank_frame_sel", o_rs[0], 8'h01);
        chk("t5_blank_frame_col", o_cd[0], 8'h00);
        chk("t5_blank_frame_col1", o_cd[1], 8'h00);
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            grid_valid = ($urandom_range(7) == 0);
            grid = {$urandom, $urandom};
            if ($urandom_range(63) == 0) enable = ~enable;
            if ($urandom_range(499) == 0) begin
                #2 reset = 1;
                #1 chk("rand_async_busy", o_busy[0], 0);
                @(negedge clk);
                reset = 0;
            end
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
